// File: rtl/conv1d_mac_engine.sv
// conv1d_mac_engine: multi-cycle 1-D convolution MAC engine behind a CFU-style
// valid/ready command/response port. Holds int8 activations and int8 weights
// in byte buffers. Computes one output position with LANES MACs per cycle.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   cmd_valid/cmd_ready command handshake; cmd (opcode), inp0, inp1 operands
//   rsp_valid/rsp_ready response handshake; ret response data
//   busy                high while a compute is stepping
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for a command, cmd_ready=1
// S_COMPUTE | one (k, chunk) MAC step per cycle, busy=1
// S_RESP    | rsp_valid=1, ret held until rsp_ready
module conv1d_mac_engine #(
  parameter int KERNEL_LENGTH = 8,
  parameter int MAX_CHANNELS  = 128,
  parameter int MAX_WIDTH     = 1024,
  parameter int LANES         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd,
  input  logic [31:0] inp0,
  input  logic [31:0] inp1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] ret,
  output logic        busy
);

  localparam int IN_BYTES   = MAX_WIDTH * MAX_CHANNELS;
  localparam int K_BYTES    = KERNEL_LENGTH * MAX_CHANNELS;
  localparam int IN_WORDS   = IN_BYTES / 4;
  localparam int K_WORDS    = K_BYTES / 4;
  localparam int IN_AW      = $clog2(IN_BYTES);
  localparam int K_AW       = $clog2(K_BYTES);
  localparam int KW         = (KERNEL_LENGTH > 1) ? $clog2(KERNEL_LENGTH) : 1;
  localparam int MAX_CHUNKS = MAX_CHANNELS / LANES;
  localparam int JW         = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
  localparam int LW         = $clog2(LANES);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_RESP} state_e;

  logic [7:0] in_mem [IN_BYTES];
  logic [7:0] k_mem  [K_BYTES];

  state_e         state_q, state_d;
  logic [31:0]    input_offset_q, input_offset_d;
  logic [31:0]    width_q, width_d;
  logic [31:0]    depth_q, depth_d;
  logic [31:0]    bias_q, bias_d;
  logic [31:0]    acc_q, acc_d;
  logic [31:0]    last_q, last_d;
  logic [31:0]    ret_q, ret_d;
  logic [31:0]    origin_q, origin_d;
  logic [31:0]    depth_e_q, depth_e_d;
  logic [31:0]    width_e_q, width_e_d;
  logic [JW-1:0]  c_last_q, c_last_d;
  logic [KW-1:0]  k_q, k_d;
  logic [JW-1:0]  j_q, j_d;

  logic           in_we, k_we;
  logic [31:0]    lane_sum;
  logic [31:0]    depth_clamp, width_clamp, chunks;
  logic [31:0]    in_rword, k_rword;

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q == S_COMPUTE);
  assign ret       = ret_q;

  assign depth_clamp = (depth_q > 32'(MAX_CHANNELS)) ? 32'(MAX_CHANNELS) : depth_q;
  assign width_clamp = (width_q > 32'(MAX_WIDTH)) ? 32'(MAX_WIDTH) : width_q;
  assign chunks      = (depth_clamp + 32'(LANES - 1)) >> LW;

  assign in_rword = {in_mem[{inp0[IN_AW-3:0], 2'd3}], in_mem[{inp0[IN_AW-3:0], 2'd2}],
                     in_mem[{inp0[IN_AW-3:0], 2'd1}], in_mem[{inp0[IN_AW-3:0], 2'd0}]};
  assign k_rword  = {k_mem[{inp0[K_AW-3:0], 2'd3}], k_mem[{inp0[K_AW-3:0], 2'd2}],
                     k_mem[{inp0[K_AW-3:0], 2'd1}], k_mem[{inp0[K_AW-3:0], 2'd0}]};

  // One step's worth of lane products; masked lanes (outside the input row
  // or beyond depth) contribute zero so latency never depends on origin.
  always_comb begin : lane_mac
    logic [31:0] x, c, in_addr, k_addr;
    logic [7:0]  in_b, w_b;
    logic        x_ok;
    lane_sum = '0;
    x        = origin_q + 32'(k_q);
    x_ok     = !x[31] && (x < width_e_q);
    for (int l = 0; l < LANES; l++) begin
      c       = (32'(j_q) << LW) + 32'(l);
      in_addr = x * depth_e_q + c;
      k_addr  = 32'(k_q) * depth_e_q + c;
      in_b    = in_mem[in_addr[IN_AW-1:0]];
      w_b     = k_mem[k_addr[K_AW-1:0]];
      if (x_ok && (c < depth_e_q) && (in_addr < 32'(IN_BYTES)) && (k_addr < 32'(K_BYTES))) begin
        lane_sum = lane_sum + {{24{w_b[7]}}, w_b} * ({{24{in_b[7]}}, in_b} + input_offset_q);
      end
    end
  end

  always_comb begin
    logic [31:0] acc_sum;
    state_d        = state_q;
    input_offset_d = input_offset_q;
    width_d        = width_q;
    depth_d        = depth_q;
    bias_d         = bias_q;
    acc_d          = acc_q;
    last_d         = last_q;
    ret_d          = ret_q;
    origin_d       = origin_q;
    depth_e_d      = depth_e_q;
    width_e_d      = width_e_q;
    c_last_d       = c_last_q;
    k_d            = k_q;
    j_d            = j_q;
    in_we          = 1'b0;
    k_we           = 1'b0;
    acc_sum        = acc_q + lane_sum;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_RESP;
          ret_d   = '0;
          case (cmd)
            7'd1: in_we = (inp0 < 32'(IN_WORDS));
            7'd2: k_we  = (inp0 < 32'(K_WORDS));
            7'd3: begin
              case (inp0)
                32'd0: begin input_offset_d = inp1; ret_d = inp1; end
                32'd1: begin width_d        = inp1; ret_d = inp1; end
                32'd2: begin depth_d        = inp1; ret_d = inp1; end
                32'd3: begin bias_d         = inp1; ret_d = inp1; end
                default: ret_d = '0;
              endcase
            end
            7'd4: begin
              state_d   = S_COMPUTE;
              acc_d     = '0;
              origin_d  = inp0;
              depth_e_d = depth_clamp;
              width_e_d = width_clamp;
              c_last_d  = (chunks == 32'd0) ? '0 : JW'(chunks - 32'd1);
              k_d       = '0;
              j_d       = '0;
              ret_d     = ret_q;
            end
            7'd5: ret_d = last_q;
            7'd6: ret_d = (inp0 < 32'(IN_WORDS)) ? in_rword : '0;
            7'd7: ret_d = (inp0 < 32'(K_WORDS)) ? k_rword : '0;
            default: ret_d = '0;
          endcase
        end
      end
      S_COMPUTE: begin
        acc_d = acc_sum;
        if (j_q == c_last_q) begin
          j_d = '0;
          if (k_q == KW'(KERNEL_LENGTH - 1)) begin
            last_d  = acc_sum + bias_q;
            ret_d   = acc_sum + bias_q;
            state_d = S_RESP;
          end else begin
            k_d = k_q + KW'(1);
          end
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      input_offset_q <= '0;
      width_q        <= '0;
      depth_q        <= '0;
      bias_q         <= '0;
      acc_q          <= '0;
      last_q         <= '0;
      ret_q          <= '0;
      origin_q       <= '0;
      depth_e_q      <= '0;
      width_e_q      <= '0;
      c_last_q       <= '0;
      k_q            <= '0;
      j_q            <= '0;
    end else begin
      state_q        <= state_d;
      input_offset_q <= input_offset_d;
      width_q        <= width_d;
      depth_q        <= depth_d;
      bias_q         <= bias_d;
      acc_q          <= acc_d;
      last_q         <= last_d;
      ret_q          <= ret_d;
      origin_q       <= origin_d;
      depth_e_q      <= depth_e_d;
      width_e_q      <= width_e_d;
      c_last_q       <= c_last_d;
      k_q            <= k_d;
      j_q            <= j_d;
    end
  end

  // Buffers are deliberately not reset.
  always_ff @(posedge clk) begin
    if (in_we) begin
      in_mem[{inp0[IN_AW-3:0], 2'd0}] <= inp1[7:0];
      in_mem[{inp0[IN_AW-3:0], 2'd1}] <= inp1[15:8];
      in_mem[{inp0[IN_AW-3:0], 2'd2}] <= inp1[23:16];
      in_mem[{inp0[IN_AW-3:0], 2'd3}] <= inp1[31:24];
    end
    if (k_we) begin
      k_mem[{inp0[K_AW-3:0], 2'd0}] <= inp1[7:0];
      k_mem[{inp0[K_AW-3:0], 2'd1}] <= inp1[15:8];
      k_mem[{inp0[K_AW-3:0], 2'd2}] <= inp1[23:16];
      k_mem[{inp0[K_AW-3:0], 2'd3}] <= inp1[31:24];
    end
  end

endmodule
